bcd_convert_6502: RTL and testbench
===================================

BCD_CONVERT_6502 -- requirements
Module: bcd_convert_6502

Interface
REQ-001 Parameters: none; iteration count fixed at 8.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 RDY  input  1  global stall; when low, all state holds.
REQ-005 start  input  1  request conversion; sampled in IDLE only.
REQ-006 mode  input  1  0 = binary-to-BCD (encode), 1 = packed-BCD-to-binary (decode); captured with start.
REQ-007 DI  input  8  operand: binary 0-255 (mode 0) or packed BCD 00-99 (mode 1); captured with start.
REQ-008 OUT  output  12  result: 3-digit packed BCD (mode 0) or zero-extended binary 0-99 (mode 1).
REQ-009 busy  output  1  high while a conversion is in progress.
REQ-010 done  output  1  one-cycle pulse; OUT and ERR valid in that cycle.
REQ-011 ERR  output  1  invalid BCD input flag (mode 1 only).

Function
REQ-012 FSM states: IDLE, SHIFT, DONE; encoding from shared package.
REQ-013 IDLE: with RDY=1 and start=1 on edge k, capture mode and DI, clear iteration counter, go SHIFT; otherwise stay.
REQ-014 SHIFT: exactly 8 cycles (counter 0-7), one iteration per RDY=1 edge; after iteration 7, go DONE.
REQ-015 Mode 0 iteration (double dabble): each of 3 BCD digits >=5 gets +3, then the 20-bit {BCD,bin} register shifts left 1.
REQ-016 Mode 1 iteration (reverse double dabble): the 16-bit {BCD,bin} register shifts right 1, then each of 2 BCD digits >=8 gets -3.
REQ-017 Digit adjust is 4-bit modulo; no carry between digits.
REQ-018 DONE: lasts one cycle; done=1; OUT loaded with result; next state IDLE.
REQ-019 Latency: start on edge k -> busy=1 in cycles k+1..k+8, done=1 in cycle k+9 (RDY held high).
REQ-020 busy=1 in SHIFT only; busy=0 in IDLE and DONE.
REQ-021 OUT and ERR hold their DONE values until the next DONE or reset.
REQ-022 start is ignored in SHIFT and DONE; no queuing.
REQ-023 Mode 1, any DI nibble >9: skip SHIFT, go IDLE->DONE directly.
REQ-024 In that case the next cycle is done=1, OUT=0, ERR=1.
REQ-025 ERR=0 on every mode 0 result and every valid mode 1 result.
REQ-026 RDY=0 in any state: state, counter, shift register, OUT, ERR, busy hold.
REQ-027 RDY=0 in DONE: done stays high until the RDY=1 edge that leaves DONE.
REQ-028 Reset asserted mid-conversion aborts it; no done pulse is produced.

Reset
REQ-029 On reset: state IDLE, counter 0, shift register 0, OUT=0, ERR=0, busy=0, done=0.
REQ-030 Reset is asynchronous assert; deassertion is synchronous to clk; RDY does not gate reset.

Structure
REQ-031 Shared package: state enum, ITER_COUNT=8, BCD digit width 4, max valid digit 9.
REQ-032 One sub-module, bcd_digit_adj: 4-bit digit in, direction in, adjusted digit out.
REQ-033 bcd_digit_adj is combinational: +3 if >=5 (encode), -3 if >=8 (decode); instantiated 3 times.
REQ-034 Total RTL 120-400 lines; no multipliers or dividers inferred.

Verification
REQ-035 Mode 0, DI=0xFF, start at edge 0 -> done at cycle 9, OUT=0x255, ERR=0.
REQ-036 Mode 1, DI=0x99 -> OUT=0x063; mode 1, DI=0x00 -> OUT=0x000.
REQ-037 Mode 1, DI=0x3A -> done next cycle, OUT=0x000, ERR=1, busy never high.
REQ-038 Mode 0, DI=0x7B, RDY low for 3 cycles mid-SHIFT -> done at cycle 12, OUT=0x123.
REQ-039 start pulsed during SHIFT with different DI -> ignored; original result returned.
REQ-040 reset asserted at cycle 4 of a conversion -> all outputs 0 immediately; no done pulse; next start converts normally.

Source files
------------

// File: rtl/bcd_convert_6502_pkg.sv
// ============================================================================
// Module  : bcd_convert_6502_pkg
// Purpose : Shared types and constants for the BCD converter: FSM state
//           encoding, iteration count, BCD digit geometry and an input
//           validity helper for packed-BCD operands.
// Ports   : none (package)
// Rev     : 1.0 - initial release
// ============================================================================
`default_nettype none

package bcd_convert_6502_pkg;

    localparam int ITER_COUNT = 8;   // one iteration per operand bit
    localparam int DIGIT_W    = 4;   // bits per BCD digit
    localparam int MAX_DIGIT  = 9;   // largest legal BCD digit value
    localparam int CNT_W      = 3;   // wide enough for 0..ITER_COUNT-1
    localparam int SR_W       = 20;  // {3 BCD digits, 8-bit binary}

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    // True when both nibbles of a packed-BCD byte are legal digits.
    function automatic logic bcd_byte_valid(input logic [7:0] b);
        return (b[7:4] <= DIGIT_W'(MAX_DIGIT)) && (b[3:0] <= DIGIT_W'(MAX_DIGIT));
    endfunction

endpackage

`default_nettype wire

// File: rtl/bcd_convert_6502_if.sv
// ============================================================================
// Module  : bcd_convert_6502_if
// Purpose : Request/result bundle of the BCD converter.
// Ports   : RDY (stall, low = hold), start, mode, DI (request side);
//           OUT, busy, done, ERR (result side).
//           slave modport is the converter, master modport the requester.
// Rev     : 1.0 - initial release
// ============================================================================
`default_nettype none

interface bcd_convert_6502_if;
    logic        RDY;
    logic        start;
    logic        mode;
    logic [7:0]  DI;
    logic [11:0] OUT;
    logic        busy;
    logic        done;
    logic        ERR;

    modport slave (
        input  RDY, start, mode, DI,
        output OUT, busy, done, ERR
    );

    modport master (
        output RDY, start, mode, DI,
        input  OUT, busy, done, ERR
    );
endinterface

`default_nettype wire

// File: rtl/bcd_convert_6502_digit_adj.sv
// ============================================================================
// Module  : bcd_digit_adj
// Purpose : Combinational single-digit correction for (reverse) double
//           dabble. Encode: +3 when digit >= 5. Decode: -3 when digit >= 8.
//           Arithmetic is 4-bit modulo; no carry leaves the digit.
// Ports   : digit_i [3:0] digit in, dir_i 0=encode 1=decode,
//           digit_o [3:0] corrected digit
// Rev     : 1.0 - initial release
// ============================================================================
`default_nettype none

module bcd_digit_adj
    import bcd_convert_6502_pkg::*;
(
    input  wire logic [DIGIT_W-1:0] digit_i,
    input  wire logic               dir_i,
    output logic      [DIGIT_W-1:0] digit_o
);

    always_comb begin
        digit_o = digit_i;
        if (dir_i) begin
            if (digit_i >= DIGIT_W'(8)) digit_o = digit_i - DIGIT_W'(3);
        end else begin
            if (digit_i >= DIGIT_W'(5)) digit_o = digit_i + DIGIT_W'(3);
        end
    end

endmodule

`default_nettype wire

// File: rtl/bcd_convert_6502.sv
// ============================================================================
// Module  : bcd_convert_6502
// Purpose : Iterative 8-bit binary <-> packed-BCD converter.
//           mode 0: binary 0-255 -> 3-digit packed BCD (double dabble)
//           mode 1: packed BCD 00-99 -> binary (reverse double dabble),
//                   illegal digits flagged on ERR without iterating.
// Ports   : clk, reset (async active-high), bus (slave modport: RDY,
//           start, mode, DI in; OUT, busy, done, ERR out)
// Rev     : 1.0 - initial release
// ============================================================================
`default_nettype none

module bcd_convert_6502
    import bcd_convert_6502_pkg::*;
(
    input  wire logic         clk,
    input  wire logic         reset,
    bcd_convert_6502_if.slave bus
);

    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(ITER_COUNT - 1);

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q,   cnt_d;
    logic [SR_W-1:0]   sr_q,    sr_d;
    logic              mode_q,  mode_d;
    logic [11:0]       out_q,   out_d;
    logic              err_q,   err_d;

    // One iteration of the datapath. Decode shifts right before adjusting,
    // encode adjusts before shifting left, so both share the same three
    // digit correctors on the upper 12 bits.
    logic [SR_W-1:0]   pre_w;
    logic [SR_W-1:0]   adj_w;
    logic [SR_W-1:0]   sr_next_w;

    // Decode keeps its 16-bit {BCD,bin} in sr_q[15:0]; the top digit is 0
    // and passes through its corrector unchanged.
    assign pre_w = mode_q ? {4'h0, 1'b0, sr_q[15:1]} : sr_q;

    assign adj_w[7:0] = pre_w[7:0];

    for (genvar g = 0; g < 3; g++) begin : g_digit
        bcd_digit_adj u_adj (
            .digit_i (pre_w[8 + g*DIGIT_W +: DIGIT_W]),
            .dir_i   (mode_q),
            .digit_o (adj_w[8 + g*DIGIT_W +: DIGIT_W])
        );
    end

    assign sr_next_w = mode_q ? adj_w : {adj_w[SR_W-2:0], 1'b0};

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sr_d    = sr_q;
        mode_d  = mode_q;
        out_d   = out_q;
        err_d   = err_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    mode_d = bus.mode;
                    cnt_d  = '0;
                    if (bus.mode && !bcd_byte_valid(bus.DI)) begin
                        // Illegal BCD: report immediately, no iterations.
                        state_d = ST_DONE;
                        sr_d    = '0;
                        out_d   = '0;
                        err_d   = 1'b1;
                    end else begin
                        state_d = ST_SHIFT;
                        sr_d    = bus.mode ? {4'h0, bus.DI, 8'h00}
                                           : {12'h000, bus.DI};
                    end
                end
            end
            ST_SHIFT: begin
                sr_d  = sr_next_w;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_ITER) begin
                    state_d = ST_DONE;
                    out_d   = mode_q ? {4'h0, sr_next_w[7:0]} : sr_next_w[19:8];
                    err_d   = 1'b0;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // RDY low freezes every register, including the DONE state itself.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            sr_q    <= '0;
            mode_q  <= 1'b0;
            out_q   <= '0;
            err_q   <= 1'b0;
        end else if (bus.RDY) begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sr_q    <= sr_d;
            mode_q  <= mode_d;
            out_q   <= out_d;
            err_q   <= err_d;
        end
    end

    assign bus.busy = (state_q == ST_SHIFT);
    assign bus.done = (state_q == ST_DONE);
    assign bus.OUT  = out_q;
    assign bus.ERR  = err_q;

endmodule

`default_nettype wire

// File: tb/tb_bcd_convert_6502.sv
// ============================================================================
// Module  : tb_bcd_convert_6502
// Purpose : Directed self-checking bench for bcd_convert_6502.
// Ports   : none
// Rev     : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bcd_convert_6502;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    bcd_convert_6502_if bus ();

    bcd_convert_6502 dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to 1 time unit after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Issue one conversion, wait (bounded) for done, check latency, result,
    // busy occupancy, pulse width and result hold.
    task automatic convert(input string tag, input logic m, input logic [7:0] di,
                           input logic [11:0] exp_out, input logic exp_err,
                           input int exp_lat);
        int n;
        int busy_cnt;
        bus.start = 1'b1;
        bus.mode  = m;
        bus.DI    = di;
        tick();
        bus.start = 1'b0;
        bus.mode  = ~m;
        bus.DI    = 8'($urandom);
        n = 1;
        busy_cnt = 0;
        while (!bus.done && n < 30) begin
            if (bus.busy) busy_cnt++;
            tick();
            n++;
        end
        check({tag, "_lat"},  32'(n), 32'(exp_lat));
        check({tag, "_out"},  32'(bus.OUT), 32'(exp_out));
        check({tag, "_err"},  32'(bus.ERR), 32'(exp_err));
        check({tag, "_busy"}, 32'(busy_cnt), 32'(exp_lat - 1));
        tick();
        check({tag, "_pulse"}, 32'(bus.done), 32'd0);
        check({tag, "_hold"},  32'(bus.OUT), 32'(exp_out));
    endtask

    initial begin
        int n;
        int done_seen;
        checks = 0;
        errors = 0;
        reset     = 1'b1;
        bus.RDY   = 1'b1;
        bus.start = 1'b0;
        bus.mode  = 1'b0;
        bus.DI    = 8'h00;
        tick();
        tick();
        check("rst_out",  32'(bus.OUT),  32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_err",  32'(bus.ERR),  32'd0);
        reset = 1'b0;
        tick();

        // Encode vectors
        convert("enc_ff", 1'b0, 8'hFF, 12'h255, 1'b0, 9);
        convert("enc_00", 1'b0, 8'h00, 12'h000, 1'b0, 9);
        convert("enc_09", 1'b0, 8'h09, 12'h009, 1'b0, 9);
        convert("enc_64", 1'b0, 8'h64, 12'h100, 1'b0, 9);
        convert("enc_80", 1'b0, 8'h80, 12'h128, 1'b0, 9);

        // Decode vectors
        convert("dec_99", 1'b1, 8'h99, 12'h063, 1'b0, 9);
        convert("dec_00", 1'b1, 8'h00, 12'h000, 1'b0, 9);
        convert("dec_45", 1'b1, 8'h45, 12'h02D, 1'b0, 9);
        convert("dec_10", 1'b1, 8'h10, 12'h00A, 1'b0, 9);

        // Illegal BCD operands: immediate done, ERR set, never busy
        convert("dec_3a", 1'b1, 8'h3A, 12'h000, 1'b1, 1);
        convert("dec_a0", 1'b1, 8'hA0, 12'h000, 1'b1, 1);
        // A following good conversion clears ERR
        convert("enc_2a", 1'b0, 8'h2A, 12'h042, 1'b0, 9);

        // Stall for 3 cycles mid-SHIFT, then stall inside DONE
        bus.start = 1'b1;
        bus.mode  = 1'b0;
        bus.DI    = 8'h7B;
        tick();
        bus.start = 1'b0;
        tick();
        tick();
        bus.RDY = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        check("stall_busy", 32'(bus.busy), 32'd1);
        bus.RDY = 1'b1;
        n = 6;
        while (!bus.done && n < 30) begin
            tick();
            n++;
        end
        check("stall_lat", 32'(n), 32'd12);
        check("stall_out", 32'(bus.OUT), 32'h123);
        bus.RDY = 1'b0;
        tick();
        tick();
        check("stall_done_hold", 32'(bus.done), 32'd1);
        bus.RDY = 1'b1;
        tick();
        check("stall_done_exit", 32'(bus.done), 32'd0);

        // start during SHIFT is ignored
        bus.start = 1'b1;
        bus.mode  = 1'b0;
        bus.DI    = 8'hFF;
        tick();
        bus.start = 1'b0;
        tick();
        tick();
        bus.start = 1'b1;
        bus.mode  = 1'b1;
        bus.DI    = 8'h12;
        tick();
        bus.start = 1'b0;
        n = 4;
        while (!bus.done && n < 30) begin
            tick();
            n++;
        end
        check("ign_lat", 32'(n), 32'd9);
        check("ign_out", 32'(bus.OUT), 32'h255);
        tick();
        check("ign_noqueue", 32'(bus.busy), 32'd0);

        // Asynchronous reset mid-conversion (OUT currently 0x255)
        bus.start = 1'b1;
        bus.mode  = 1'b0;
        bus.DI    = 8'hC8;
        tick();
        bus.start = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        #2;
        reset = 1'b1;
        #1;
        check("arst_out",  32'(bus.OUT),  32'd0);
        check("arst_busy", 32'(bus.busy), 32'd0);
        check("arst_done", 32'(bus.done), 32'd0);
        check("arst_err",  32'(bus.ERR),  32'd0);
        tick();
        reset = 1'b0;
        done_seen = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (bus.done || bus.busy) done_seen++;
        end
        check("arst_no_done", 32'(done_seen), 32'd0);
        convert("post_rst", 1'b0, 8'hC8, 12'h200, 1'b0, 9);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
